// File: rtl/pc_redirect_if.sv
// pc_redirect_if
//   Bundles the fetch-PC redirect request channels and the fetch PC status
//   outputs of pc_redirect_unit.
//   master : drives redirect requests, stall and fetch_ready; observes PC state.
//   slave  : the redirect unit itself.
//   Signals:
//     redirect_valid  per-source redirect request, bit i = source i
//     redirect_pc     per-source target, slice [i*PC_WIDTH +: PC_WIDTH]
//     stall           pipeline stall, fetch must not advance
//     fetch_ready     instruction memory accepts the current PC
//     pc              current fetch PC
//     pc_src          0 = sequential, i+1 = redirect from source i
//     pending_valid   a redirect is buffered
//     pending_src     encoded source of the buffered redirect (0 = none)
//     pc_misaligned   pc[1:0] != 0
//     redirect_cnt    saturating count of applied redirects
interface pc_redirect_if #(
  parameter int NUM_SRC  = 6,
  parameter int PC_WIDTH = 32,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(NUM_SRC + 1)
);
  logic [NUM_SRC-1:0]          redirect_valid;
  logic [NUM_SRC*PC_WIDTH-1:0] redirect_pc;
  logic                        stall;
  logic                        fetch_ready;
  logic [PC_WIDTH-1:0]         pc;
  logic [SEL_W-1:0]            pc_src;
  logic                        pending_valid;
  logic [SEL_W-1:0]            pending_src;
  logic                        pc_misaligned;
  logic [CNT_W-1:0]            redirect_cnt;

  modport master (
    output redirect_valid, redirect_pc, stall, fetch_ready,
    input  pc, pc_src, pending_valid, pending_src, pc_misaligned, redirect_cnt
  );

  modport slave (
    input  redirect_valid, redirect_pc, stall, fetch_ready,
    output pc, pc_src, pending_valid, pending_src, pc_misaligned, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Owns the IF-stage fetch PC. Arbitrates NUM_SRC prioritised redirect
//   requests (index 0 = highest priority, oldest stage). When fetch cannot
//   advance the winning redirect is parked in a single pending slot and
//   applied on the next advance.
//   Ports:
//     clk     clock, rising edge
//     resetn  asynchronous active-low reset
//     bus     pc_redirect_if.slave: redirect requests in, fetch PC state out
module pc_redirect_unit #(
  parameter int                    NUM_SRC  = 6,
  parameter int                    PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = 32'hBFC0_0000,
  parameter int                    PC_INC   = 4,
  parameter int                    CNT_W    = 16,
  parameter int                    SEL_W    = $clog2(NUM_SRC + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  pc_redirect_if.slave  bus
);

  // Per-source targets unpacked from the flat bus.
  logic [PC_WIDTH-1:0] tgt [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign tgt[gi] = bus.redirect_pc[gi*PC_WIDTH +: PC_WIDTH];
  end

  // State
  logic [PC_WIDTH-1:0] pc_reg;
  logic [SEL_W-1:0]    pc_src_reg;
  logic                pend_valid_reg;
  logic [SEL_W-1:0]    pend_src_reg;
  logic [PC_WIDTH-1:0] pend_pc_reg;
  logic [CNT_W-1:0]    cnt_reg;

  // Combinational decision signals
  logic                advance;
  logic                win_valid;
  logic [SEL_W-1:0]    win_src;
  logic [PC_WIDTH-1:0] win_pc;
  logic                win_takes;
  logic                eff_valid;
  logic [SEL_W-1:0]    eff_src;
  logic [PC_WIDTH-1:0] eff_pc;
  logic [PC_WIDTH-1:0] seq_pc;

  assign advance = bus.fetch_ready & ~bus.stall;

  // Fixed-priority pick: scan from the lowest-priority source upward so the
  // last match written (lowest index) wins.
  always_comb begin
    win_valid = 1'b0;
    win_src   = '0;
    win_pc    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.redirect_valid[i]) begin
        win_valid = 1'b1;
        win_src   = SEL_W'(i + 1);
        win_pc    = tgt[i];
      end
    end
  end

  // A new winner of equal or higher priority (smaller or equal encoding)
  // replaces the buffered one; equal index means the newer event of the same
  // stage, which supersedes the older one.
  assign win_takes = win_valid & (~pend_valid_reg | (win_src <= pend_src_reg));

  always_comb begin
    eff_valid = 1'b0;
    eff_src   = '0;
    eff_pc    = '0;
    if (win_takes) begin
      eff_valid = 1'b1;
      eff_src   = win_src;
      eff_pc    = win_pc;
    end else if (pend_valid_reg) begin
      eff_valid = 1'b1;
      eff_src   = pend_src_reg;
      eff_pc    = pend_pc_reg;
    end
  end

  // Sequential step wraps modulo 2^PC_WIDTH.
  assign seq_pc = pc_reg + PC_WIDTH'(PC_INC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_reg         <= RESET_PC;
      pc_src_reg     <= '0;
      pend_valid_reg <= 1'b0;
      pend_src_reg   <= '0;
      pend_pc_reg    <= '0;
      cnt_reg        <= '0;
    end else if (advance) begin
      if (eff_valid) begin
        pc_reg     <= eff_pc;
        pc_src_reg <= eff_src;
        if (cnt_reg != {CNT_W{1'b1}}) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        pc_reg     <= seq_pc;
        pc_src_reg <= '0;
      end
      pend_valid_reg <= 1'b0;
      pend_src_reg   <= '0;
      pend_pc_reg    <= '0;
    end else if (win_takes) begin
      pend_valid_reg <= 1'b1;
      pend_src_reg   <= win_src;
      pend_pc_reg    <= win_pc;
    end
  end

  assign bus.pc            = pc_reg;
  assign bus.pc_src        = pc_src_reg;
  assign bus.pending_valid = pend_valid_reg;
  assign bus.pending_src   = pend_src_reg;
  assign bus.pc_misaligned = |pc_reg[1:0];
  assign bus.redirect_cnt  = cnt_reg;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit
//   Scoreboard bench for pc_redirect_unit. Two instances share stimulus:
//   one with a 16-bit redirect counter and one with a 2-bit counter to hit
//   saturation quickly. Stimulus is driven on the falling edge, the
//   reference model result is queued, and a monitor compares one
//   queued entry after each rising edge.
module tb_pc_redirect_unit;
  localparam int NS = 6;
  localparam int PW = 32;
  localparam int SW = 3;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pc_redirect_if #(.NUM_SRC(NS), .PC_WIDTH(PW), .CNT_W(16)) bus_a ();
  pc_redirect_if #(.NUM_SRC(NS), .PC_WIDTH(PW), .CNT_W(2))  bus_b ();

  pc_redirect_unit #(.NUM_SRC(NS), .PC_WIDTH(PW), .CNT_W(16)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a));
  pc_redirect_unit #(.NUM_SRC(NS), .PC_WIDTH(PW), .CNT_W(2)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b));

  typedef struct {
    logic [31:0] pc;
    int          src;
    bit          pv;
    int          ps;
    int          cnt16;
    int          cnt2;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_src, m_ps, m_cnt16, m_cnt2;
  bit          m_pv;
  logic [31:0] m_pt;
  logic [31:0] tgt [NS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_src = 0; m_pv = 0; m_ps = 0; m_pt = 0;
    m_cnt16 = 0; m_cnt2 = 0;
  endtask

  // Apply one cycle of inputs to the model following the redirect rules.
  task automatic model_step(input logic [NS-1:0] v, input bit st, input bit rdy);
    int  w;
    bit  has_eff;
    int  e_src;
    logic [31:0] e_pc;
    bit  win_ok;
    w = -1;
    for (int i = 0; i < NS; i++) begin
      if (v[i]) begin w = i; break; end
    end
    win_ok  = (w >= 0) && (!m_pv || (w + 1) <= m_ps);
    has_eff = 0; e_src = 0; e_pc = 0;
    if (win_ok) begin has_eff = 1; e_src = w + 1; e_pc = tgt[w]; end
    else if (m_pv) begin has_eff = 1; e_src = m_ps; e_pc = m_pt; end
    if (rdy && !st) begin
      if (has_eff) begin
        m_pc = e_pc; m_src = e_src;
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end else begin
        m_pc = m_pc + 32'd4; m_src = 0;
      end
      m_pv = 0; m_ps = 0; m_pt = 0;
    end else if (win_ok) begin
      m_pv = 1; m_ps = w + 1; m_pt = tgt[w];
    end
  endtask

  // Drive one cycle at a falling edge, queue the expectation, wait a cycle.
  task automatic cycle(input logic [NS-1:0] v, input bit st, input bit rdy);
    exp_t e;
    logic [NS*PW-1:0] flat;
    for (int i = 0; i < NS; i++) flat[i*PW +: PW] = tgt[i];
    bus_a.redirect_valid = v; bus_a.redirect_pc = flat;
    bus_a.stall = st; bus_a.fetch_ready = rdy;
    bus_b.redirect_valid = v; bus_b.redirect_pc = flat;
    bus_b.stall = st; bus_b.fetch_ready = rdy;
    model_step(v, st, rdy);
    e.pc = m_pc; e.src = m_src; e.pv = m_pv; e.ps = m_ps;
    e.cnt16 = m_cnt16; e.cnt2 = m_cnt2;
    exp_q.push_back(e);
    $display("txn v=%b stall=%0d rdy=%0d -> pc=%h src=%0d pend=%0d/%0d cnt=%0d",
             v, st, rdy, m_pc, m_src, m_pv, m_ps, m_cnt16);
    @(negedge clk);
  endtask

  // Monitor: one registered result per rising edge while out of reset.
  always @(posedge clk) begin
    #1;
    if (resetn && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc",            64'(bus_a.pc),            64'(e.pc));
      chk("pc_src",        64'(bus_a.pc_src),        64'(e.src));
      chk("pending_valid", 64'(bus_a.pending_valid), 64'(e.pv));
      chk("pending_src",   64'(bus_a.pending_src),   64'(e.ps));
      chk("redirect_cnt",  64'(bus_a.redirect_cnt),  64'(e.cnt16));
      chk("pc_misaligned", 64'(bus_a.pc_misaligned), 64'(e.pc[1:0] != 2'b00));
      chk("pc_b",          64'(bus_b.pc),            64'(e.pc));
      chk("redirect_cnt2", 64'(bus_b.redirect_cnt),  64'(e.cnt2));
    end
  end

  task automatic clear_tgts();
    for (int i = 0; i < NS; i++) tgt[i] = 32'h0;
  endtask

  initial begin
    clear_tgts();
    model_reset();
    bus_a.redirect_valid = '0; bus_a.redirect_pc = '0; bus_a.stall = 0; bus_a.fetch_ready = 0;
    bus_b.redirect_valid = '0; bus_b.redirect_pc = '0; bus_b.stall = 0; bus_b.fetch_ready = 0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_pc",      64'(bus_a.pc),            64'(RST_PC));
    chk("reset_pc_src",  64'(bus_a.pc_src),        64'd0);
    chk("reset_pend",    64'(bus_a.pending_valid), 64'd0);
    chk("reset_cnt",     64'(bus_a.redirect_cnt),  64'd0);
    resetn = 1'b1;

    // 1: free run from reset
    repeat (3) cycle('0, 0, 1);

    // 2: simultaneous redirects, source 2 beats source 4
    tgt[2] = 32'h8000_1000; tgt[4] = 32'h8000_2000;
    cycle(6'b010100, 0, 1);
    cycle('0, 0, 1);

    // 3: stall buffering and override
    tgt[3] = 32'h1000; cycle(6'b001000, 1, 1);
    tgt[5] = 32'h2000; cycle(6'b100000, 1, 1);
    tgt[1] = 32'h3000; cycle(6'b000010, 1, 1);
    cycle('0, 1, 1);
    cycle('0, 0, 1);
    cycle('0, 0, 1);

    // 4: fetch_ready back-pressure, same index replaces
    tgt[0] = 32'h100; cycle(6'b000001, 0, 0);
    tgt[0] = 32'h200; cycle(6'b000001, 0, 0);
    cycle('0, 0, 1);

    // 5: wrap-around and counter saturation
    tgt[0] = 32'hFFFF_FFFC; cycle(6'b000001, 0, 1);
    cycle('0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      tgt[k] = 32'h5000 + 32'(k * 16);
      cycle(NS'(1 << k), 0, 1);
    end

    // 6: asynchronous reset while a redirect is pending
    tgt[2] = 32'h4000; cycle(6'b000100, 1, 1);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("async_pc",       64'(bus_a.pc),            64'(RST_PC));
    chk("async_pend_v",   64'(bus_a.pending_valid), 64'd0);
    chk("async_pend_src", 64'(bus_a.pending_src),   64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) cycle('0, 0, 1);

    // misaligned target loads as-is
    tgt[0] = 32'h4002; cycle(6'b000001, 0, 1);
    cycle('0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++)
        tgt[i] = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      v = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      cycle(v, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end

    @(posedge clk); #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
